// File: rtl/lpgbt_uplink_bringup_ctrl_pkg.sv
// Shared types for the lpGBT uplink bring-up sequencer.
// State encodings are visible on state_o for status readback.
package lpgbt_bringup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  localparam int SAT_W = 16;

endpackage

// File: rtl/lpgbt_uplink_bringup_ctrl_if.sv
// Signals between the bring-up sequencer and the lpGBT uplink core.
// master = sequencer, slave = uplink core / MGT side.
interface lpgbt_uplink_bringup_ctrl_if;

  logic mgt_rx_rdy_i;
  logic uplinkrdy_i;
  logic uplinkFEC_i;
  logic uplinkRst_o;
  logic mgt_rxpolarity_o;

  modport master (
    input  mgt_rx_rdy_i,
    input  uplinkrdy_i,
    input  uplinkFEC_i,
    output uplinkRst_o,
    output mgt_rxpolarity_o
  );

  modport slave (
    output mgt_rx_rdy_i,
    output uplinkrdy_i,
    output uplinkFEC_i,
    input  uplinkRst_o,
    input  mgt_rxpolarity_o
  );

endinterface

// File: rtl/lpgbt_uplink_bringup_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module lpgbt_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lpgbt_uplink_bringup_ctrl.sv
// lpGBT uplink bring-up sequencer: reset, lock wait, qualify, retry.
// Define LPGBT_BRINGUP_FEC_MON_EN to build the FEC event counter.
module lpgbt_uplink_bringup_ctrl
  import lpgbt_bringup_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 8,
  parameter int CNT_W               = 21
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 enable_i,
  input  logic                 relock_i,
  input  logic                 pol_auto_i,
  input  logic                 pol_init_i,
  lpgbt_uplink_bringup_ctrl_if.master core,
  output logic                 locked_o,
  output logic                 fail_o,
  output logic [2:0]           state_o,
  output logic [7:0]           retry_cnt_o,
  output logic [SAT_W-1:0]     lock_loss_cnt_o,
  output logic [SAT_W-1:0]     fec_cnt_o
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] timer_q;
  logic [7:0]       retry_q;
  logic [7:0]       retry_inc;
  logic             pol_q;
  logic             rst_q;
  logic             locked_q;
  logic             fail_q;
  logic             both;
  logic             fail_path;
  logic             relock_go;
  logic             entry;
  logic             loss_inc;

  assign both      = core.mgt_rx_rdy_i & core.uplinkrdy_i;
  assign retry_inc = retry_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    fail_path = 1'b0;
    relock_go = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (relock_i && state_q != ST_IDLE) begin
      state_d   = ST_RESET;
      relock_go = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RESET;
        ST_RESET: begin
          if (timer_q == CNT_W'(RST_HOLD_CYCLES - 1))
            state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (both) begin
            state_d = ST_STABLE;
          end else if (timer_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            fail_path = 1'b1;
            state_d   = (retry_inc == 8'(MAX_RETRIES)) ?
                        ST_FAIL : ST_RESET;
          end
        end
        ST_STABLE: begin
          if (!both)
            state_d = ST_WAIT;
          else if (timer_q == CNT_W'(STABLE_CYCLES - 1))
            state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (!both)
            state_d = ST_RESET;
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // relock from RESET re-enters the same state, so it must also restart the timer
  assign entry = (state_d != state_q) || relock_go;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      retry_q  <= '0;
      pol_q    <= 1'b0;
      rst_q    <= 1'b1;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rst_q    <= state_d inside {ST_IDLE, ST_RESET, ST_FAIL};
      locked_q <= (state_d == ST_LOCKED);
      fail_q   <= (state_d == ST_FAIL);
      if (entry)
        timer_q <= '0;
      else if (timer_q != '1)
        timer_q <= timer_q + CNT_W'(1);
      if (enable_i && state_q == ST_IDLE) begin
        pol_q   <= pol_init_i;
        retry_q <= '0;
      end else if (relock_go) begin
        pol_q   <= pol_init_i;
        retry_q <= '0;
      end else if (fail_path) begin
        retry_q <= retry_inc;
        if (pol_auto_i)
          pol_q <= ~pol_q;
      end
    end
  end

  // a loss coinciding with relock is still counted; disable wins outright
  assign loss_inc = enable_i && state_q == ST_LOCKED && !both;

  lpgbt_sat_counter #(.WIDTH(SAT_W)) u_loss_cnt (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .inc   (loss_inc),
    .clr   (1'b0),
    .count (lock_loss_cnt_o)
  );

`ifdef LPGBT_BRINGUP_FEC_MON_EN
  logic fec_inc;
  logic fec_clr;

  assign fec_inc = (state_q == ST_LOCKED) && core.uplinkFEC_i;
  assign fec_clr = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);

  lpgbt_sat_counter #(.WIDTH(SAT_W)) u_fec_cnt (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .inc   (fec_inc),
    .clr   (fec_clr),
    .count (fec_cnt_o)
  );
`else
  logic unused_fec;

  assign unused_fec = core.uplinkFEC_i;
  assign fec_cnt_o  = '0;
`endif

  assign core.uplinkRst_o      = rst_q;
  assign core.mgt_rxpolarity_o = pol_q;
  assign locked_o              = locked_q;
  assign fail_o                = fail_q;
  assign state_o               = state_q;
  assign retry_cnt_o           = retry_q;

endmodule

// File: tb/tb_lpgbt_uplink_bringup_ctrl.sv
// Directed bench for lpgbt_uplink_bringup_ctrl with short timing params.
// Expected fec_cnt_o follows LPGBT_BRINGUP_FEC_MON_EN.
module tb_lpgbt_uplink_bringup_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        relock;
  logic        pol_auto;
  logic        pol_init;
  logic        locked;
  logic        fail;
  logic [2:0]  state;
  logic [7:0]  retry;
  logic [15:0] loss;
  logic [15:0] fec;
  int          checks = 0;
  int          errors = 0;

  lpgbt_uplink_bringup_ctrl_if core_if();

  lpgbt_uplink_bringup_ctrl #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (3),
    .CNT_W               (21)
  ) dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rstn),
    .enable_i        (enable),
    .relock_i        (relock),
    .pol_auto_i      (pol_auto),
    .pol_init_i      (pol_init),
    .core            (core_if),
    .locked_o        (locked),
    .fail_o          (fail),
    .state_o         (state),
    .retry_cnt_o     (retry),
    .lock_loss_cnt_o (loss),
    .fec_cnt_o       (fec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] exp, input int budget);
    int n = 0;
    while (state !== exp && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", {29'd0, state}, {29'd0, exp});
  endtask

  initial begin
    logic [15:0] fec_exp;
`ifdef LPGBT_BRINGUP_FEC_MON_EN
    fec_exp = 16'd5;
`else
    fec_exp = 16'd0;
`endif
    rstn = 1'b0;
    enable = 1'b0;
    relock = 1'b0;
    pol_auto = 1'b0;
    pol_init = 1'b1;
    core_if.mgt_rx_rdy_i = 1'b0;
    core_if.uplinkrdy_i = 1'b0;
    core_if.uplinkFEC_i = 1'b0;
    tick();
    tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_uprst", {31'd0, core_if.uplinkRst_o}, 32'd1);
    chk("rst_pol", {31'd0, core_if.mgt_rxpolarity_o}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);
    chk("rst_retry", {24'd0, retry}, 32'd0);
    chk("rst_loss", {16'd0, loss}, 32'd0);
    chk("rst_fec", {16'd0, fec}, 32'd0);
    rstn = 1'b1;
    tick();
    chk("idle_hold", {29'd0, state}, 32'd0);

    // nominal bring-up
    enable = 1'b1;
    tick();
    chk("nom_reset", {29'd0, state}, 32'd1);
    chk("nom_pol_load", {31'd0, core_if.mgt_rxpolarity_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nom_rst_hold", {31'd0, core_if.uplinkRst_o}, 32'd1);
    end
    tick();
    chk("nom_wait", {29'd0, state}, 32'd2);
    chk("nom_rst_fall", {31'd0, core_if.uplinkRst_o}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("nom_still_wait", {29'd0, state}, 32'd2);
    core_if.mgt_rx_rdy_i = 1'b1;
    core_if.uplinkrdy_i = 1'b1;
    tick();
    chk("nom_stable", {29'd0, state}, 32'd3);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("nom_not_locked", {31'd0, locked}, 32'd0);
    end
    tick();
    chk("nom_locked", {31'd0, locked}, 32'd1);
    chk("nom_state4", {29'd0, state}, 32'd4);

    // lock loss
    core_if.mgt_rx_rdy_i = 1'b0;
    tick();
    chk("loss_state", {29'd0, state}, 32'd1);
    chk("loss_uprst", {31'd0, core_if.uplinkRst_o}, 32'd1);
    chk("loss_cnt", {16'd0, loss}, 32'd1);
    chk("loss_locked", {31'd0, locked}, 32'd0);
    chk("loss_retry", {24'd0, retry}, 32'd0);

    // glitch in STABLE
    wait_state(3'd2, 10);
    core_if.mgt_rx_rdy_i = 1'b1;
    tick();
    chk("gl_stable", {29'd0, state}, 32'd3);
    for (int i = 0; i < 4; i++) tick();
    core_if.uplinkrdy_i = 1'b0;
    tick();
    chk("gl_back_wait", {29'd0, state}, 32'd2);
    core_if.uplinkrdy_i = 1'b1;
    tick();
    chk("gl_restable", {29'd0, state}, 32'd3);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("gl_not_locked", {31'd0, locked}, 32'd0);
    end
    tick();
    chk("gl_locked", {31'd0, locked}, 32'd1);

    // disable from LOCKED
    enable = 1'b0;
    tick();
    chk("dis_idle", {29'd0, state}, 32'd0);
    chk("dis_locked", {31'd0, locked}, 32'd0);
    chk("dis_uprst", {31'd0, core_if.uplinkRst_o}, 32'd1);
    chk("dis_loss_kept", {16'd0, loss}, 32'd1);

    // retries with polarity toggling
    core_if.mgt_rx_rdy_i = 1'b0;
    core_if.uplinkrdy_i = 1'b0;
    pol_auto = 1'b1;
    pol_init = 1'b0;
    enable = 1'b1;
    tick();
    chk("rt_pol_init", {31'd0, core_if.mgt_rxpolarity_o}, 32'd0);
    wait_state(3'd2, 10);
    for (int i = 0; i < 31; i++) tick();
    chk("rt_to_edge", {29'd0, state}, 32'd2);
    tick();
    chk("rt1_state", {29'd0, state}, 32'd1);
    chk("rt1_retry", {24'd0, retry}, 32'd1);
    chk("rt1_pol", {31'd0, core_if.mgt_rxpolarity_o}, 32'd1);
    wait_state(3'd2, 10);
    wait_state(3'd1, 40);
    chk("rt2_retry", {24'd0, retry}, 32'd2);
    chk("rt2_pol", {31'd0, core_if.mgt_rxpolarity_o}, 32'd0);
    wait_state(3'd2, 10);
    wait_state(3'd5, 40);
    chk("rt3_fail", {31'd0, fail}, 32'd1);
    chk("rt3_retry", {24'd0, retry}, 32'd3);
    chk("rt3_uprst", {31'd0, core_if.uplinkRst_o}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("fail_hold", {29'd0, state}, 32'd5);

    // relock out of FAIL
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk("rl_state", {29'd0, state}, 32'd1);
    chk("rl_fail", {31'd0, fail}, 32'd0);
    chk("rl_retry", {24'd0, retry}, 32'd0);
    chk("rl_pol", {31'd0, core_if.mgt_rxpolarity_o}, 32'd0);

    // disable mid-WAIT_LOCK
    wait_state(3'd2, 10);
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0;
    tick();
    chk("dw_idle", {29'd0, state}, 32'd0);
    chk("dw_uprst", {31'd0, core_if.uplinkRst_o}, 32'd1);

    // FEC monitoring while LOCKED
    core_if.mgt_rx_rdy_i = 1'b1;
    core_if.uplinkrdy_i = 1'b1;
    enable = 1'b1;
    tick();
    wait_state(3'd4, 40);
    core_if.uplinkFEC_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    core_if.uplinkFEC_i = 1'b0;
    tick();
    chk("fec_cnt", {16'd0, fec}, {16'd0, fec_exp});

    // relock wins over a same-cycle lock loss, which is still counted
    core_if.mgt_rx_rdy_i = 1'b0;
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk("rlloss_state", {29'd0, state}, 32'd1);
    chk("rlloss_cnt", {16'd0, loss}, 32'd2);
    core_if.mgt_rx_rdy_i = 1'b1;
    wait_state(3'd4, 40);
    chk("fec_clr", {16'd0, fec}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
